ftdi_sync245_ctrl: RTL and testbench

Parametrised FTDI synchronous 245-FIFO bus controller for FT232H (8-bit), FT600 (16-bit) and FT601 (32-bit). It runs entirely in the `usb_clk` domain, between the user-side TX/RX stream FIFOs and the chip pins. It adds three things to the single-width controller:

- byte-enable handling for partial words;
- bounded-burst round-robin arbitration between RX and TX;
- an age-based TX flush.

Clock-domain crossing stays outside, in the existing stream FIFOs.

---
 rtl/ftdi_pkg.sv | 22 ++
 rtl/ftdi_rx_skid.sv | 56 +++++
 rtl/ftdi_sync245_ctrl.sv | 143 ++++++++++++++
 tb/tb_ftdi_sync245_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types for the FTDI synchronous 245-FIFO controller.
// States, transfer direction and the legal bus-width check.
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_RXOE,
        ST_RXD,
        ST_TXD
    } ftdi_state_e;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } ftdi_dir_e;

    function automatic bit bus_bytes_ok(input int bytes);
        return (bytes == 1) || (bytes == 2) || (bytes == 4);
    endfunction

endpackage

// File: rtl/ftdi_rx_skid.sv
// Two-entry in-order RX skid buffer (data plus keep).
// Entry 0 is always the head presented to the consumer.
module ftdi_rx_skid #(
    parameter int W = 9
) (
    input  logic         usb_clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic [1:0]   cnt_q;
    logic         pop;

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = ent0_q;
    assign count     = cnt_q;

    // The producer never pushes while two entries are held.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= push_data;
                    else               ent1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                2'b00: ;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_sync245_ctrl.sv
// FTDI sync 245-FIFO bus controller (FT232H/FT600/FT601) with
// round-robin bounded bursts, byte enables and aged TX flush.
module ftdi_sync245_ctrl
    import ftdi_pkg::*;
#(
    parameter int BUS_BYTES    = 1,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_BURST    = 256,
    parameter int TX_THRESH    = 64,
    parameter int FLUSH_CYCLES = 1024,
    parameter int LEVEL_W      = 12
) (
    input  logic                   usb_clk,
    input  logic                   rst_n,
    output logic                   link_up,
    input  logic                   tx_tvalid,
    output logic                   tx_tready,
    input  logic [8*BUS_BYTES-1:0] tx_tdata,
    input  logic [BUS_BYTES-1:0]   tx_tkeep,
    input  logic [LEVEL_W-1:0]     tx_level,
    output logic                   rx_tvalid,
    input  logic                   rx_tready,
    output logic [8*BUS_BYTES-1:0] rx_tdata,
    output logic [BUS_BYTES-1:0]   rx_tkeep,
    input  logic                   usb_rxf_n,
    input  logic                   usb_txe_n,
    output logic                   usb_oe_n,
    output logic                   usb_rd_n,
    output logic                   usb_wr_n,
    input  logic [8*BUS_BYTES-1:0] usb_data_i,
    output logic [8*BUS_BYTES-1:0] usb_data_o,
    output logic                   usb_data_oe,
    input  logic [BUS_BYTES-1:0]   usb_be_i,
    output logic [BUS_BYTES-1:0]   usb_be_o
);

    localparam int DW    = 8 * BUS_BYTES;
    localparam int AGE_W = $clog2(FLUSH_CYCLES + 1);

    if (!bus_bytes_ok(BUS_BYTES)) begin : g_bad_bus_bytes
        $error("ftdi_sync245_ctrl: BUS_BYTES must be 1, 2 or 4");
    end

    ftdi_state_e          state_q;
    ftdi_state_e          state_d;
    ftdi_dir_e            last_dir_q;
    logic [7:0]           rst_cnt_q;
    logic [15:0]          burst_q;
    logic [AGE_W-1:0]     age_q;
    logic [1:0]           skid_cnt;
    logic                 rx_elig;
    logic                 tx_elig;
    logic                 burst_end;
    logic                 rd;
    logic                 wr;
    logic [BUS_BYTES-1:0] rx_keep_in;

    // Link stays up until the next reset, since RESET is never re-entered.
    assign link_up    = (state_q != ST_RESET);
    assign usb_data_o = tx_tdata;
    assign usb_be_o   = tx_tkeep;
    assign rx_keep_in = (BUS_BYTES == 1) ? {BUS_BYTES{1'b1}} : usb_be_i;

    always_comb begin
        state_d     = state_q;
        usb_oe_n    = 1'b1;
        usb_rd_n    = 1'b1;
        usb_wr_n    = 1'b1;
        usb_data_oe = 1'b0;
        tx_tready   = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        rx_elig     = !usb_rxf_n && (skid_cnt < 2'd2);
        tx_elig     = !usb_txe_n && tx_tvalid &&
                      ((tx_level >= LEVEL_W'(TX_THRESH)) ||
                       (age_q >= AGE_W'(FLUSH_CYCLES)));
        burst_end   = (burst_q == 16'(MAX_BURST - 1));
        unique case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == 8'(RESET_CYCLES - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_elig && (!tx_elig || last_dir_q == DIR_TX))
                    state_d = ST_RXOE;
                else if (tx_elig)
                    state_d = ST_TXD;
            end
            ST_RXOE: begin
                usb_oe_n = 1'b0;
                state_d  = usb_rxf_n ? ST_IDLE : ST_RXD;
            end
            ST_RXD: begin
                usb_oe_n = 1'b0;
                rd       = !usb_rxf_n && (skid_cnt < 2'd2);
                usb_rd_n = !rd;
                if (usb_rxf_n || (rd && burst_end)) state_d = ST_IDLE;
            end
            ST_TXD: begin
                usb_data_oe = 1'b1;
                wr          = !usb_txe_n && tx_tvalid;
                usb_wr_n    = !wr;
                tx_tready   = wr;
                if (!wr || burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            last_dir_q <= DIR_TX;
            rst_cnt_q  <= 8'd0;
            burst_q    <= 16'd0;
            age_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RESET) rst_cnt_q <= rst_cnt_q + 8'd1;
            if (state_q == ST_IDLE)  burst_q <= 16'd0;
            else if (rd || wr)       burst_q <= burst_q + 16'd1;
            if (state_q == ST_RXOE)     last_dir_q <= DIR_RX;
            else if (state_q == ST_TXD) last_dir_q <= DIR_TX;
            if (!tx_tvalid || wr)
                age_q <= '0;
            else if (age_q != AGE_W'(FLUSH_CYCLES))
                age_q <= age_q + AGE_W'(1);
        end
    end

    ftdi_rx_skid #(
        .W(DW + BUS_BYTES)
    ) u_skid (
        .usb_clk  (usb_clk),
        .rst_n    (rst_n),
        .push     (rd),
        .push_data({rx_keep_in, usb_data_i}),
        .out_valid(rx_tvalid),
        .out_ready(rx_tready),
        .out_data ({rx_tkeep, rx_tdata}),
        .count    (skid_cnt)
    );

endmodule

// File: tb/tb_ftdi_sync245_ctrl.sv
// Bench for ftdi_sync245_ctrl: vector table, directed corner cases
// and randomized traffic against queue-based chip/user models.
module tb_ftdi_sync245_ctrl;

    localparam int BB    = 4;
    localparam int RSTC  = 16;
    localparam int MAXB  = 256;
    localparam int FLUSH = 1024;

    logic        usb_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        link_up;
    logic        tx_tvalid = 1'b0;
    logic        tx_tready;
    logic [31:0] tx_tdata = '0;
    logic [3:0]  tx_tkeep = 4'hf;
    logic [11:0] tx_level = '0;
    logic        rx_tvalid;
    logic        rx_tready = 1'b1;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        usb_rxf_n = 1'b1;
    logic        usb_txe_n = 1'b1;
    logic        usb_oe_n;
    logic        usb_rd_n;
    logic        usb_wr_n;
    logic [31:0] usb_data_i = '0;
    logic [31:0] usb_data_o;
    logic        usb_data_oe;
    logic [3:0]  usb_be_i = 4'hf;
    logic [3:0]  usb_be_o;

    ftdi_sync245_ctrl #(
        .BUS_BYTES(BB), .RESET_CYCLES(RSTC), .MAX_BURST(MAXB),
        .TX_THRESH(64), .FLUSH_CYCLES(FLUSH), .LEVEL_W(12)
    ) dut (
        .usb_clk(usb_clk), .rst_n(rst_n), .link_up(link_up),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_level(tx_level),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
        .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
        .usb_oe_n(usb_oe_n), .usb_rd_n(usb_rd_n), .usb_wr_n(usb_wr_n),
        .usb_data_i(usb_data_i), .usb_data_o(usb_data_o),
        .usb_data_oe(usb_data_oe), .usb_be_i(usb_be_i), .usb_be_o(usb_be_o)
    );

    always #5 usb_clk = ~usb_clk;

    typedef logic [35:0] word_t;
    typedef struct { int dir; int len; int start; } run_t;
    typedef struct {
        logic rxf_n; logic txe_n; logic tv; logic [11:0] lvl;
        logic [31:0] din; logic [5:0] exp; logic [31:0] exp_d;
    } vec_t;

    word_t chip_q[$];
    word_t exp_rx_q[$];
    word_t user_q[$];
    run_t  runs_q[$];
    vec_t  tbl[16];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_wr = 0, first_wr = -1, n_rx_got = 0;
    int cur_dir = 0, cur_len = 0, cur_start = 0;
    int rxf_p = 0, txe_p = 0, tv_p = 0, rdy_p = 100;
    bit rdy_third = 0, lvl_rand = 0;
    int lvl_fix = 0;
    bit prev_oe = 0, prev_doe = 0;
    logic [3:0] last_be = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)",
                     nm, act, exp, cyc, $time);
        end
    endtask

    function automatic word_t rand_word();
        logic [3:0] k;
        case ($urandom_range(3))
            0: k = 4'b0001;
            1: k = 4'b0011;
            2: k = 4'b0111;
            default: k = 4'b1111;
        endcase
        return {k, 32'($urandom)};
    endfunction

    // One bus cycle: drive the chip/user models, then check and account.
    task automatic tick();
        logic rd, wr, pop;
        int d;
        @(negedge usb_clk);
        usb_rxf_n  = !(chip_q.size() > 0 && $urandom_range(99) < rxf_p);
        {usb_be_i, usb_data_i} = (chip_q.size() > 0) ? chip_q[0] : '0;
        usb_txe_n  = !($urandom_range(99) < txe_p);
        tx_tvalid  = user_q.size() > 0 && $urandom_range(99) < tv_p;
        {tx_tkeep, tx_tdata} = (user_q.size() > 0) ? user_q[0] : '0;
        tx_level   = lvl_rand ? 12'($urandom_range(127)) : 12'(lvl_fix);
        rx_tready  = rdy_third ? (cyc % 3 == 0)
                               : ($urandom_range(99) < rdy_p);
        #1;
        rd  = !usb_rd_n;
        wr  = !usb_wr_n;
        pop = rx_tvalid && rx_tready;
        chk("rx_tvalid", 64'(rx_tvalid), 64'(exp_rx_q.size() > 0));
        chk("tx_tready", 64'(tx_tready), 64'(wr));
        chk("rd_and_wr", 64'(rd && wr), 64'd0);
        chk("turnaround", 64'((usb_data_oe && (prev_oe || !usb_oe_n)) ||
                              (!usb_oe_n && prev_doe)), 64'd0);
        if (rd) begin
            chk("rd_flag", 64'(usb_rxf_n), 64'd0);
            chk("rd_skid_full", 64'(exp_rx_q.size() < 2), 64'd1);
        end
        if (wr) chk("wr_flags", 64'({usb_txe_n, tx_tvalid}), 64'b01);
        if (pop) begin
            if (exp_rx_q.size() == 0) begin
                chk("rx_spurious", 64'd1, 64'd0);
            end else begin
                chk("rx_word", 64'({rx_tkeep, rx_tdata}), 64'(exp_rx_q[0]));
                void'(exp_rx_q.pop_front());
            end
            n_rx_got++;
        end
        if (rd && !usb_rxf_n && chip_q.size() > 0)
            exp_rx_q.push_back(chip_q.pop_front());
        if (wr) begin
            if (user_q.size() == 0) begin
                chk("tx_spurious", 64'd1, 64'd0);
            end else begin
                chk("tx_word", 64'({usb_be_o, usb_data_o}), 64'(user_q[0]));
                void'(user_q.pop_front());
            end
            n_wr++;
            last_be = usb_be_o;
            if (first_wr < 0) first_wr = cyc;
        end
        d = rd ? 1 : (wr ? 2 : 0);
        if (d != cur_dir) begin
            if (cur_dir != 0)
                runs_q.push_back('{dir: cur_dir, len: cur_len, start: cur_start});
            cur_dir = d; cur_len = 1; cur_start = cyc;
        end else if (d != 0) begin
            cur_len++;
        end
        prev_oe  = !usb_oe_n;
        prev_doe = usb_data_oe;
        cyc++;
    endtask

    task automatic set_pol(input int rx, input int txe, input int tv,
                           input int lvl);
        rxf_p = rx; txe_p = txe; tv_p = tv; lvl_fix = lvl;
        rdy_p = 100; rdy_third = 0; lvl_rand = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        usb_rxf_n = 1'b0; usb_txe_n = 1'b0; tx_tvalid = 1'b1;
        tx_level = 12'd64; rx_tready = 1'b1;
        #1;
        chk("rst_link_up", 64'(link_up), 64'd0);
        chk("rst_strobes", 64'({usb_oe_n, usb_rd_n, usb_wr_n}), 64'b111);
        chk("rst_data_oe", 64'(usb_data_oe), 64'd0);
        chk("rst_tready", 64'(tx_tready), 64'd0);
        chk("rst_rx_tvalid", 64'(rx_tvalid), 64'd0);
        repeat (3) @(negedge usb_clk);
        rst_n = 1'b1;
        for (int k = 1; k <= RSTC; k++) begin
            @(posedge usb_clk);
            #1;
            chk($sformatf("link_up_edge%0d", k), 64'(link_up), 64'(k == RSTC));
            chk("wait_strobes",
                64'({usb_oe_n, usb_rd_n, usb_wr_n, usb_data_oe}), 64'b1110);
        end
        usb_rxf_n = 1'b1;
        tx_tvalid = 1'b0;
        exp_rx_q.delete();
        cur_dir = 0; prev_oe = 0; prev_doe = 0;
    endtask

    task automatic drain(input string nm);
        int i;
        set_pol(100, 100, 100, 64);
        i = 0;
        while (i < 5000 && (chip_q.size() + exp_rx_q.size() + user_q.size()) != 0) begin
            tick();
            i++;
        end
        chk(nm, 64'(chip_q.size() + exp_rx_q.size() + user_q.size()), 64'd0);
        set_pol(0, 100, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        int t0;
        // {rxf_n, txe_n, tv, lvl, din, {oe,rd,wr,doe,trdy,rxv}, rx data}
        tbl[0]  = '{1, 0, 0, 0,  0,            6'b111000, 0};
        tbl[1]  = '{0, 1, 0, 0,  0,            6'b111000, 0};
        tbl[2]  = '{0, 1, 0, 0,  0,            6'b011000, 0};
        tbl[3]  = '{0, 1, 0, 0,  32'hA5A50001, 6'b001000, 0};
        tbl[4]  = '{1, 1, 0, 0,  0,            6'b011001, 32'hA5A50001};
        tbl[5]  = '{1, 0, 1, 64, 0,            6'b111000, 0};
        tbl[6]  = '{1, 0, 1, 64, 0,            6'b110110, 0};
        tbl[7]  = '{1, 1, 1, 64, 0,            6'b111100, 0};
        tbl[8]  = '{0, 0, 1, 64, 0,            6'b111000, 0};
        tbl[9]  = '{0, 0, 1, 64, 0,            6'b011000, 0};
        tbl[10] = '{1, 0, 0, 0,  0,            6'b011000, 0};
        tbl[11] = '{1, 1, 0, 0,  0,            6'b111000, 0};
        tbl[12] = '{0, 0, 1, 64, 0,            6'b111000, 0};
        tbl[13] = '{0, 0, 1, 64, 0,            6'b110110, 0};
        tbl[14] = '{1, 1, 0, 0,  0,            6'b111100, 0};
        tbl[15] = '{1, 1, 0, 0,  0,            6'b111000, 0};

        do_reset();

        rx_tready = 1'b1; usb_be_i = 4'hf; tx_tkeep = 4'hf; tx_tdata = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge usb_clk);
            usb_rxf_n  = tbl[i].rxf_n;
            usb_txe_n  = tbl[i].txe_n;
            tx_tvalid  = tbl[i].tv;
            tx_level   = tbl[i].lvl;
            usb_data_i = tbl[i].din;
            #1;
            chk($sformatf("vec%0d_pins", i),
                64'({usb_oe_n, usb_rd_n, usb_wr_n, usb_data_oe,
                     tx_tready, rx_tvalid}), 64'(tbl[i].exp));
            if (tbl[i].exp[0])
                chk($sformatf("vec%0d_rxd", i), 64'(rx_tdata), 64'(tbl[i].exp_d));
        end

        // Sustained RX: 300 words, bursts of 256 then 44.
        set_pol(100, 100, 0, 0);
        repeat (2) tick();
        for (int i = 0; i < 300; i++) chip_q.push_back(rand_word());
        runs_q.delete(); n_rx_got = 0;
        for (int i = 0; i < 400 && n_rx_got < 300; i++) tick();
        repeat (2) tick();
        chk("rx300_count", 64'(n_rx_got), 64'd300);
        chk("rx300_runs", 64'(runs_q.size()), 64'd2);
        if (runs_q.size() >= 2) begin
            chk("rx300_run0", 64'(runs_q[0].len), 64'(MAXB));
            chk("rx300_run1", 64'(runs_q[1].len), 64'(300 - MAXB));
            chk("rx300_gap", 64'(runs_q[1].start - runs_q[0].start - runs_q[0].len),
                64'd2);
        end

        // RX backpressure: consumer ready one cycle in three.
        for (int i = 0; i < 60; i++) chip_q.push_back(rand_word());
        n_rx_got = 0; rdy_third = 1;
        for (int i = 0; i < 400 && n_rx_got < 60; i++) tick();
        chk("bp_count", 64'(n_rx_got), 64'd60);
        rdy_third = 0;
        repeat (3) tick();

        // Threshold send, TXE dropped after 10 writes.
        for (int i = 0; i < 20; i++) user_q.push_back(rand_word());
        set_pol(0, 100, 100, 64);
        n_wr = 0; first_wr = -1; t0 = cyc;
        for (int i = 0; i < 50 && n_wr < 10; i++) tick();
        txe_p = 0;
        repeat (4) tick();
        chk("thr_writes", 64'(n_wr), 64'd10);
        chk("thr_latency", 64'(first_wr >= 0 && first_wr - t0 <= 2), 64'd1);
        chk("thr_idle", 64'(usb_data_oe), 64'd0);

        // Reset in the middle of a TX burst.
        txe_p = 100; n_wr = 0;
        for (int i = 0; i < 10 && n_wr == 0; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes",
            64'({usb_oe_n, usb_rd_n, usb_wr_n, usb_data_oe, tx_tready}), 64'b11100);
        do_reset();
        user_q.delete();
        set_pol(0, 100, 0, 0);
        repeat (3) tick();

        // Aged flush of a single partial word.
        user_q.push_back({4'b0011, 32'hCAFE0001});
        set_pol(0, 100, 100, 1);
        n_wr = 0; first_wr = -1; t0 = cyc;
        for (int i = 0; i < FLUSH + 100 && n_wr == 0; i++) tick();
        chk("flush_writes", 64'(n_wr), 64'd1);
        chk("flush_delay", 64'(first_wr - t0), 64'(FLUSH + 1));
        chk("flush_be", 64'(last_be), 64'b0011);
        set_pol(0, 100, 0, 0);
        repeat (3) tick();

        // Contention: both directions always eligible.
        for (int i = 0; i < 1100; i++) begin
            chip_q.push_back(rand_word());
            user_q.push_back(rand_word());
        end
        set_pol(100, 100, 100, 64);
        runs_q.delete();
        repeat (1300) tick();
        chk("cont_runs", 64'(runs_q.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < runs_q.size(); i++) begin
            chk($sformatf("cont_len%0d", i), 64'(runs_q[i].len), 64'(MAXB));
            if (i > 0)
                chk($sformatf("cont_alt%0d", i),
                    64'(runs_q[i].dir != runs_q[i-1].dir), 64'd1);
        end
        drain("cont_drain");

        // Randomized mixed traffic.
        set_pol(70, 70, 70, 0);
        lvl_rand = 1; rdy_p = 60;
        for (int i = 0; i < 2000; i++) begin
            if (chip_q.size() < 4 && $urandom_range(1)) chip_q.push_back(rand_word());
            if (user_q.size() < 4 && $urandom_range(1)) user_q.push_back(rand_word());
            tick();
        end
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
